debounce_pulse_gen: RTL and testbench
=====================================

Name: debounce_pulse_gen

Overview:
- Upstream conditioning stage for the team's 1-bit toggle counter.
- Takes a raw, asynchronous, bouncing push-button or switch input and synchronises it to clk1.
- Debounces the input with a stability counter and FSM.
- Emits a clean debounced level plus single-cycle press/release pulses; press_pulse is the count/clock-enable source for the downstream 1-bit counter.

Parameters:
- STABLE_CNT, 50000: consecutive synchronised cycles the input must hold a new value before it is accepted (1 ms at 50 MHz); legal range >= 2.
- CNT_W, 16: stability counter width; requires 2**CNT_W >= STABLE_CNT (elaboration-time check, fatal on violation).

Ports:
- clk1  input  1  system clock, rising-edge active
- clr_n  input  1  asynchronous active-low reset
- btn_in  input  1  raw button/switch, asynchronous to clk1, may bounce
- btn_level  output  1  debounced level of btn_in
- press_pulse  output  1  one-cycle high on accepted 0->1 transition
- release_pulse  output  1  one-cycle high on accepted 1->0 transition
- busy  output  1  high while a candidate transition is being qualified (WAIT states)

Behaviour:
- Clock and reset: one clock, clk1. Reset clr_n is asynchronous and active-low. Assertion immediately forces all flops to reset values; deassertion is sampled on clk1.
- Reset values: btn_level=0, press_pulse=0, release_pulse=0, busy=0, sync flops=0, counter=0, state=IDLE_LOW.
- Synchroniser: two-flop chain on btn_in, output btn_sync. btn_in is used nowhere else.
- FSM states: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW. All outputs are registered.
- IDLE_LOW: if btn_sync=1, go to WAIT_HIGH with cnt<=0; else stay.
- WAIT_HIGH: if btn_sync=0, return to IDLE_LOW (bounce rejected, no pulse). Else if cnt==STABLE_CNT-1, go to IDLE_HIGH, btn_level<=1, press_pulse<=1. Else cnt<=cnt+1.
- IDLE_HIGH / WAIT_LOW: mirror images with polarity inverted. Acceptance sets btn_level<=0 and release_pulse<=1.
- Pulses are high for exactly one clk1 cycle, then return to 0 on the next edge. press_pulse and release_pulse are never high in the same cycle.
- busy is 1 exactly while the state is WAIT_HIGH or WAIT_LOW.
- Latency: btn_in stable from edge 0 gives sync at edge 1, WAIT entry at edge 2, and btn_level/pulse asserted after edge 2+STABLE_CNT.
- Bounce restart: any opposite sample in a WAIT state aborts qualification. The next qualifying sample restarts cnt from 0 and never resumes a partial count.
- Counter: counts only in WAIT states and holds 0 in IDLE states. It never wraps, because it is bounded by STABLE_CNT-1.
- Reset mid-operation: abandons qualification with no pulse. If btn_in is still high after release, the input is requalified from IDLE_LOW and press_pulse fires after full latency.

Decomposition:
- Package debounce_pkg: state encoding constants (IDLE_LOW=2'b00, WAIT_HIGH=2'b01, IDLE_HIGH=2'b11, WAIT_LOW=2'b10) and the CNT_W sizing check function.
- Sub-module sync_2ff: 1-bit two-flop synchroniser with clk1 and clr_n (async active-low, resets to 0), instantiated once.
- FSM, counter and output registers stay in debounce_pulse_gen.

Test Plan:
1. Reset values (STABLE_CNT=4): hold clr_n=0 with btn_in=1 -> all outputs 0 and state IDLE_LOW throughout.
2. Clean press: release reset, btn_in 0->1 held high before edge 0 -> busy high after edge 2; btn_level=1 and press_pulse=1 after edge 6; press_pulse=0 after edge 7; busy=0 after edge 6.
3. Glitch rejection: btn_in high for 3 cycles, then low -> busy pulses, btn_level stays 0, press_pulse never asserts.
4. Bounce restart: high 2 cycles, low 1 cycle, then high steady -> acceptance occurs STABLE_CNT cycles after the second WAIT_HIGH entry, not earlier.
5. Release: from btn_level=1, btn_in 1->0 held -> release_pulse one cycle and btn_level=0 at the same latency as the press case; press_pulse stays 0.
6. Reset mid-qualification: clr_n pulsed low while in WAIT_HIGH with cnt=2, btn_in held high -> immediate zero outputs, no pulse during reset; exactly one press_pulse 2+STABLE_CNT edges after release.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared definitions for the button debouncer: FSM state encoding and the
// elaboration-time counter sizing check.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'b00,
        WAIT_HIGH = 2'b01,
        IDLE_HIGH = 2'b11,
        WAIT_LOW  = 2'b10
    } state_t;

    // True when a CNT_W-bit counter can hold every value 0..stable_cnt-1.
    function automatic bit cnt_w_fits(input int cnt_w, input int stable_cnt);
        return (longint'(1) << cnt_w) >= longint'(stable_cnt);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser bringing a single asynchronous bit into the clk1 domain.
module sync_2ff (
    input  logic clk1,
    input  logic clr_n,
    input  logic async_bit,
    output logic sync_bit
);

    logic sync_p0;
    logic sync_p1;

    always_ff @(posedge clk1 or negedge clr_n) begin
        if (!clr_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= async_bit;
            sync_p1 <= sync_p0;
        end
    end

    assign sync_bit = sync_p1;

endmodule

// File: rtl/debounce_pulse_gen.sv
// Debounces a raw button input and produces a clean level plus one-cycle
// press/release pulses; press_pulse feeds the downstream toggle counter enable.
module debounce_pulse_gen
    import debounce_pkg::*;
#(
    parameter int STABLE_CNT = 50000,
    parameter int CNT_W      = 16
) (
    input  logic clk1,
    input  logic clr_n,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic busy
);

    if (STABLE_CNT < 2 || !cnt_w_fits(CNT_W, STABLE_CNT)) begin : g_param_check
        $fatal(1, "debounce_pulse_gen: STABLE_CNT must be >= 2 and fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

    logic             btn_sync;
    state_t           state;
    logic [CNT_W-1:0] cnt;

    sync_2ff u_sync (
        .clk1      (clk1),
        .clr_n     (clr_n),
        .async_bit (btn_in),
        .sync_bit  (btn_sync)
    );

    // Any opposite sample during a WAIT state drops back to IDLE, so a later
    // attempt always starts counting from zero again.
    always_ff @(posedge clk1 or negedge clr_n) begin
        if (!clr_n) begin
            state         <= IDLE_LOW;
            cnt           <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            busy          <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            case (state)
                IDLE_LOW: begin
                    if (btn_sync) begin
                        state <= WAIT_HIGH;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    if (!btn_sync) begin
                        state <= IDLE_LOW;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state       <= IDLE_HIGH;
                        cnt         <= '0;
                        busy        <= 1'b0;
                        btn_level   <= 1'b1;
                        press_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                IDLE_HIGH: begin
                    if (!btn_sync) begin
                        state <= WAIT_LOW;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                WAIT_LOW: begin
                    if (btn_sync) begin
                        state <= IDLE_HIGH;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state         <= IDLE_LOW;
                        cnt           <= '0;
                        busy          <= 1'b0;
                        btn_level     <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE_LOW;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debounce_pulse_gen.sv
// Bench for debounce_pulse_gen: scenario tasks plus randomized bouncing input,
// checked against a run-length reference model of the debounce rule.
module tb_debounce_pulse_gen;
    import debounce_pkg::*;

    localparam int S  = 4;
    localparam int CW = 3;

    logic clk1 = 1'b0;
    logic clr_n = 1'b0;
    logic btn_in = 1'b0;
    logic btn_level, press_pulse, release_pulse, busy;

    int total = 0;
    int bad   = 0;

    debounce_pulse_gen #(.STABLE_CNT(S), .CNT_W(CW)) dut (
        .clk1          (clk1),
        .clr_n         (clr_n),
        .btn_in        (btn_in),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .busy          (busy)
    );

    always #5 clk1 = ~clk1;

    // Reference model: the value seen by the debounce logic at an edge is the
    // input sampled two edges earlier. The level flips once S+1 consecutive
    // seen values differ from it; any agreeing value clears the run.
    logic d0, d1, m_level, m_press, m_rel, m_busy;
    int   run, run_nxt;

    always_comb run_nxt = (d1 != m_level) ? run + 1 : 0;

    always @(posedge clk1 or negedge clr_n) begin
        if (!clr_n) begin
            d0 <= 1'b0; d1 <= 1'b0; run <= 0;
            m_level <= 1'b0; m_press <= 1'b0; m_rel <= 1'b0; m_busy <= 1'b0;
        end else begin
            d1 <= d0;
            d0 <= btn_in;
            if (run_nxt == S + 1) begin
                run <= 0; m_level <= d1; m_press <= d1; m_rel <= !d1; m_busy <= 1'b0;
            end else begin
                run <= run_nxt; m_press <= 1'b0; m_rel <= 1'b0; m_busy <= (run_nxt != 0);
            end
        end
    end

    task automatic tick(input logic b);
        btn_in = b;
        @(posedge clk1);
        @(negedge clk1);
    endtask

    task automatic test_reset();
        clr_n  = 1'b0;
        btn_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk1);
            total++;
            if ({btn_level, press_pulse, release_pulse, busy} !== 4'b0000 || dut.state !== IDLE_LOW) begin
                bad++;
                $display("FAIL reset k=%0d got=%b st=%b want=0000 st=00", k,
                         {btn_level, press_pulse, release_pulse, busy}, dut.state);
            end
        end
        btn_in = 1'b0;
        clr_n  = 1'b1;
        for (int k = 0; k < 4; k++) tick(1'b0);
    endtask

    task automatic test_clean_press();
        for (int k = 0; k < 10; k++) begin
            tick(1'b1);
            total++;
            if ({btn_level, press_pulse, release_pulse, busy} !== {m_level, m_press, m_rel, m_busy}) begin
                bad++;
                $display("FAIL press_model edge=%0d got=%b want=%b", k,
                         {btn_level, press_pulse, release_pulse, busy}, {m_level, m_press, m_rel, m_busy});
            end
            if (k == 1 || k == 2 || k == 6 || k == 7) begin
                logic [3:0] want;
                case (k)
                    1:       want = 4'b0000;
                    2:       want = 4'b0001;
                    6:       want = 4'b1100;
                    default: want = 4'b1000;
                endcase
                total++;
                if ({btn_level, press_pulse, release_pulse, busy} !== want) begin
                    bad++;
                    $display("FAIL press_timing edge=%0d got=%b want=%b", k,
                             {btn_level, press_pulse, release_pulse, busy}, want);
                end
            end
        end
    endtask

    task automatic test_release();
        int npress = 0;
        for (int k = 0; k < 10; k++) begin
            tick(1'b0);
            npress += int'(press_pulse);
            total++;
            if ({btn_level, press_pulse, release_pulse, busy} !== {m_level, m_press, m_rel, m_busy}) begin
                bad++;
                $display("FAIL release_model edge=%0d got=%b want=%b", k,
                         {btn_level, press_pulse, release_pulse, busy}, {m_level, m_press, m_rel, m_busy});
            end
            if (k == 5 || k == 6 || k == 7) begin
                logic [3:0] want;
                want = (k == 5) ? 4'b1001 : (k == 6) ? 4'b0010 : 4'b0000;
                total++;
                if ({btn_level, press_pulse, release_pulse, busy} !== want) begin
                    bad++;
                    $display("FAIL release_timing edge=%0d got=%b want=%b", k,
                             {btn_level, press_pulse, release_pulse, busy}, want);
                end
            end
        end
        total++;
        if (npress != 0) begin
            bad++;
            $display("FAIL release_no_press got=%0d want=0", npress);
        end
    endtask

    task automatic test_glitch();
        int npress = 0;
        int nbusy  = 0;
        for (int k = 0; k < 12; k++) begin
            tick(k < 3 ? 1'b1 : 1'b0);
            npress += int'(press_pulse);
            nbusy  += int'(busy);
            total++;
            if ({btn_level, press_pulse, release_pulse, busy} !== {m_level, m_press, m_rel, m_busy}) begin
                bad++;
                $display("FAIL glitch_model edge=%0d got=%b want=%b", k,
                         {btn_level, press_pulse, release_pulse, busy}, {m_level, m_press, m_rel, m_busy});
            end
        end
        total++;
        if (npress != 0 || nbusy != 3 || btn_level !== 1'b0) begin
            bad++;
            $display("FAIL glitch_summary press=%0d busy=%0d level=%b want 0 3 0", npress, nbusy, btn_level);
        end
    endtask

    task automatic test_bounce_restart();
        for (int k = 0; k < 12; k++) begin
            tick((k == 2) ? 1'b0 : 1'b1);
            total++;
            if ({btn_level, press_pulse, release_pulse, busy} !== {m_level, m_press, m_rel, m_busy}) begin
                bad++;
                $display("FAIL bounce_model edge=%0d got=%b want=%b", k,
                         {btn_level, press_pulse, release_pulse, busy}, {m_level, m_press, m_rel, m_busy});
            end
            if (k == 8 || k == 9) begin
                logic [1:0] want;
                want = (k == 8) ? 2'b00 : 2'b11;
                total++;
                if ({btn_level, press_pulse} !== want) begin
                    bad++;
                    $display("FAIL bounce_timing edge=%0d got=%b want=%b", k, {btn_level, press_pulse}, want);
                end
            end
        end
    endtask

    task automatic test_reset_mid_qual();
        int npress = 0;
        int at     = -1;
        for (int k = 0; k < 5; k++) tick(1'b1);
        total++;
        if (busy !== 1'b1 || btn_level !== 1'b0) begin
            bad++;
            $display("FAIL midrst_pre busy=%b level=%b want 1 0", busy, btn_level);
        end
        clr_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if ({btn_level, press_pulse, release_pulse, busy} !== 4'b0000) begin
                bad++;
                $display("FAIL midrst_hold k=%0d got=%b want=0000", k, {btn_level, press_pulse, release_pulse, busy});
            end
            @(negedge clk1);
        end
        clr_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick(1'b1);
            if (press_pulse === 1'b1) begin
                npress++;
                at = k;
            end
            total++;
            if ({btn_level, press_pulse, release_pulse, busy} !== {m_level, m_press, m_rel, m_busy}) begin
                bad++;
                $display("FAIL midrst_model edge=%0d got=%b want=%b", k,
                         {btn_level, press_pulse, release_pulse, busy}, {m_level, m_press, m_rel, m_busy});
            end
        end
        total++;
        if (npress != 1 || at != 2 + S) begin
            bad++;
            $display("FAIL midrst_press count=%0d edge=%0d want 1 at %0d", npress, at, 2 + S);
        end
    endtask

    task automatic test_random();
        int cyc = 0;
        for (int seg = 0; seg < 80; seg++) begin
            logic v;
            int   len;
            v   = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 10));
            for (int j = 0; j < len; j++) begin
                tick(v);
                cyc++;
                total++;
                if ({btn_level, press_pulse, release_pulse, busy} !== {m_level, m_press, m_rel, m_busy}
                    || (press_pulse && release_pulse)) begin
                    bad++;
                    $display("FAIL random cyc=%0d got=%b want=%b", cyc,
                             {btn_level, press_pulse, release_pulse, busy}, {m_level, m_press, m_rel, m_busy});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_release();
        test_glitch();
        test_bounce_restart();
        for (int k = 0; k < 10; k++) tick(1'b0);
        test_reset_mid_qual();
        for (int k = 0; k < 10; k++) tick(1'b0);
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
